// File: rtl/viterbi_link_ctrl.sv
// Frame sequencer for the encoder / channel / Viterbi link: PRBS7 payload, zero flush
// tail, periodic channel error-injection schedule and decoded-bit error counting.
module viterbi_link_ctrl #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned TAIL_LEN  = 2,
    parameter int unsigned DEC_LAT   = 16,
    parameter int unsigned INJ_DLY   = 1,
    parameter logic [6:0]  LFSR_SEED = 7'h7F,
    parameter int unsigned CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          cfg_err_en_i,
    input  logic [7:0]    cfg_err_period_i,
    input  logic [7:0]    cfg_err_offset_i,
    input  logic [7:0]    cfg_err_burst_i,
    input  logic          dec_bit_i,
    output logic          enc_en_o,
    output logic          enc_bit_o,
    output logic [1:0]    err_inj_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] bit_err_ct_o,
    output logic [CW-1:0] inj_ct_o
);

    localparam int unsigned NW = $clog2(FRAME_LEN + TAIL_LEN + 1) + 1;
    localparam logic [DEC_LAT-1:0] TOP_MASK = DEC_LAT'(1) << (DEC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_TAIL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [6:0]       lfsr;
    logic [NW-1:0]    cnt;
    logic [7:0]       pos;
    logic             cfg_en;
    logic [7:0]       cfg_period;
    logic [7:0]       cfg_offset;
    logic [7:0]       cfg_burst;
    logic [DEC_LAT-1:0] dl_bit;
    logic [DEC_LAT-1:0] dl_vld;
    logic [INJ_DLY:0] inj_ln;

    logic             issue_c;
    logic             act_c;
    logic             en_c;
    logic [7:0]       per_c;
    logic [7:0]       off_c;
    logic [7:0]       bur_c;
    logic [7:0]       pos_c;
    logic [7:0]       pos_nxt_c;
    logic [DEC_LAT-1:0] rest_c;

    function automatic logic [6:0] prbs_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    // Config/position seen by the bit issued at the coming edge (live inputs on start)
    always_comb begin
        en_c  = cfg_en;
        per_c = cfg_period;
        off_c = cfg_offset;
        bur_c = cfg_burst;
        pos_c = pos;
        if (state == S_IDLE) begin
            en_c  = cfg_err_en_i;
            per_c = cfg_err_period_i;
            off_c = cfg_err_offset_i;
            bur_c = cfg_err_burst_i;
            pos_c = 8'd0;
        end
    end

    assign act_c = en_c && (per_c != 8'd0) && (pos_c >= off_c) && (pos_c < per_c)
                   && (9'(pos_c) < 9'(off_c) + 9'(bur_c));
    assign pos_nxt_c = (9'(pos_c) + 9'd1 == 9'(per_c)) ? 8'd0 : pos_c + 8'd1;

    // High when the coming edge launches an encoder bit (payload or tail)
    always_comb begin
        issue_c = 1'b0;
        case (state)
            S_IDLE:    issue_c = start_i;
            S_PAYLOAD: issue_c = !abort_i && ((cnt != NW'(FRAME_LEN)) || (TAIL_LEN != 0));
            S_TAIL:    issue_c = !abort_i && (cnt != NW'(TAIL_LEN));
            default:   issue_c = 1'b0;
        endcase
    end

    // Payload bits still in flight once the current compare retires
    assign rest_c    = dl_vld & ~TOP_MASK;
    assign err_inj_o = {inj_ln[INJ_DLY], 1'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            lfsr         <= LFSR_SEED;
            cnt          <= '0;
            pos          <= '0;
            cfg_en       <= 1'b0;
            cfg_period   <= '0;
            cfg_offset   <= '0;
            cfg_burst    <= '0;
            dl_bit       <= '0;
            dl_vld       <= '0;
            inj_ln       <= '0;
            enc_en_o     <= 1'b0;
            enc_bit_o    <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            bit_err_ct_o <= '0;
            inj_ct_o     <= '0;
        end else begin
            done_o <= 1'b0;
            dl_bit <= DEC_LAT'({dl_bit, enc_bit_o});
            dl_vld <= DEC_LAT'({dl_vld, state == S_PAYLOAD});
            inj_ln <= (INJ_DLY + 1)'({inj_ln, issue_c && act_c});

            if (dl_vld[DEC_LAT-1] && (dec_bit_i != dl_bit[DEC_LAT-1]) && (bit_err_ct_o != '1))
                bit_err_ct_o <= bit_err_ct_o + CW'(1);

            if (issue_c) begin
                pos <= pos_nxt_c;
                if (act_c && (inj_ct_o != '1))
                    inj_ct_o <= inj_ct_o + CW'(1);
            end

            if ((state != S_IDLE) && abort_i) begin
                state     <= S_IDLE;
                enc_en_o  <= 1'b0;
                enc_bit_o <= 1'b0;
                busy_o    <= 1'b0;
                dl_vld    <= '0;
                inj_ln    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            state        <= S_PAYLOAD;
                            lfsr         <= prbs_step(LFSR_SEED);
                            enc_en_o     <= 1'b1;
                            enc_bit_o    <= LFSR_SEED[6];
                            cnt          <= NW'(1);
                            busy_o       <= 1'b1;
                            bit_err_ct_o <= '0;
                            inj_ct_o     <= CW'(act_c);
                            cfg_en       <= cfg_err_en_i;
                            cfg_period   <= cfg_err_period_i;
                            cfg_offset   <= cfg_err_offset_i;
                            cfg_burst    <= cfg_err_burst_i;
                        end
                    end
                    S_PAYLOAD: begin
                        if (cnt == NW'(FRAME_LEN)) begin
                            cnt       <= NW'(1);
                            enc_bit_o <= 1'b0;
                            if (TAIL_LEN != 0) begin
                                state <= S_TAIL;
                            end else begin
                                state    <= S_DRAIN;
                                enc_en_o <= 1'b0;
                            end
                        end else begin
                            enc_bit_o <= lfsr[6];
                            lfsr      <= prbs_step(lfsr);
                            cnt       <= cnt + NW'(1);
                        end
                    end
                    S_TAIL: begin
                        if (cnt == NW'(TAIL_LEN)) begin
                            state    <= S_DRAIN;
                            enc_en_o <= 1'b0;
                        end else begin
                            cnt <= cnt + NW'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (rest_c == '0) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Bench for viterbi_link_ctrl: PRBS recurrence, injection schedule and error-count
// reference model; a small CW=4 / TAIL_LEN=0 / INJ_DLY=0 build checks saturation.
`timescale 1ns/1ps
module tb_viterbi_link_ctrl;

    localparam int FRAME_LEN = 256;
    localparam int TAIL_LEN  = 2;
    localparam int DEC_LAT   = 16;
    localparam int INJ_DLY   = 1;
    localparam logic [6:0] SEED = 7'h7F;
    localparam int NPOS = FRAME_LEN + TAIL_LEN;
    localparam int TMAX = 320;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, abort = 1'b0, cfg_en = 1'b0, dec_bit = 1'b0;
    logic [7:0]  cfg_per = '0, cfg_off = '0, cfg_bur = '0;
    logic        enc_en, enc_bit, busy, done;
    logic [1:0]  err_inj;
    logic [15:0] bit_err_ct, inj_ct;

    logic        s_start = 1'b0, s_abort = 1'b0, s_cfg_en = 1'b0, s_dec = 1'b0;
    logic [7:0]  s_per = '0, s_off = '0, s_bur = '0;
    logic        s_enc_en, s_enc_bit, s_busy, s_done;
    logic [1:0]  s_err_inj;
    logic [3:0]  s_bit_err, s_inj;

    viterbi_link_ctrl u_dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .cfg_err_en_i(cfg_en), .cfg_err_period_i(cfg_per), .cfg_err_offset_i(cfg_off),
        .cfg_err_burst_i(cfg_bur), .dec_bit_i(dec_bit), .enc_en_o(enc_en), .enc_bit_o(enc_bit),
        .err_inj_o(err_inj), .busy_o(busy), .done_o(done), .bit_err_ct_o(bit_err_ct),
        .inj_ct_o(inj_ct)
    );

    viterbi_link_ctrl #(.FRAME_LEN(20), .TAIL_LEN(0), .DEC_LAT(3), .INJ_DLY(0), .CW(4)) u_small (
        .clk(clk), .rst(rst), .start_i(s_start), .abort_i(s_abort),
        .cfg_err_en_i(s_cfg_en), .cfg_err_period_i(s_per), .cfg_err_offset_i(s_off),
        .cfg_err_burst_i(s_bur), .dec_bit_i(s_dec), .enc_en_o(s_enc_en), .enc_bit_o(s_enc_bit),
        .err_inj_o(s_err_inj), .busy_o(s_busy), .done_o(s_done), .bit_err_ct_o(s_bit_err),
        .inj_ct_o(s_inj)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame recorder and decoder model: decoded bit = transmitted bit DEC_LAT cycles ago ^ inv
    bit         in_frame = 1'b0;
    int         ft = -1;
    int         done_cnt = 0;
    int         done_ft = -1;
    logic       rec_en [TMAX];
    logic       rec_bit[TMAX];
    logic [1:0] rec_inj[TMAX];
    bit         inv    [TMAX];

    always begin
        @(posedge clk);
        #1;
        if (in_frame) ft++;
        else if (enc_en === 1'b1) begin
            in_frame = 1'b1;
            ft = 0;
        end
        if (in_frame && ft < TMAX) begin
            rec_en[ft]  = enc_en;
            rec_bit[ft] = enc_bit;
            rec_inj[ft] = err_inj;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_ft = ft;
        end
        if (in_frame && ft >= DEC_LAT && ft - DEC_LAT < TMAX)
            dec_bit = rec_bit[ft-DEC_LAT] ^ inv[ft-DEC_LAT];
        else
            dec_bit = 1'b0;
    end

    logic [2:0] s_hist = '0;
    int s_inj_cyc = 0, s_inj_off = 0, s_done_cnt = 0;

    always begin
        @(posedge clk);
        #1;
        s_dec  = ~s_hist[2];
        s_hist = {s_hist[1:0], s_enc_bit};
        if (s_err_inj === 2'b10) s_inj_cyc++;
        if (s_err_inj !== 2'b00 && s_enc_en !== 1'b1) s_inj_off++;
        if (s_done === 1'b1) s_done_cnt++;
    end

    bit prbs[NPOS];

    function automatic bit pos_active(int p, bit en, int per, int off, int bur);
        int ph;
        if (!en || per == 0) return 1'b0;
        ph = p % per;
        return (ph >= off) && (ph < off + bur) && (ph < per);
    endfunction

    task automatic clear_inv();
        for (int i = 0; i < TMAX; i++) inv[i] = 1'b0;
    endtask

    task automatic begin_frame(input bit en, input int per, input int off, input int bur);
        @(negedge clk);
        for (int i = 0; i < TMAX; i++) begin
            rec_en[i] = 1'b0; rec_bit[i] = 1'b0; rec_inj[i] = 2'b00;
        end
        in_frame = 1'b0; ft = -1; done_cnt = 0; done_ft = -1;
        cfg_en = en; cfg_per = 8'(per); cfg_off = 8'(off); cfg_bur = 8'(bur);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_en = 1'($urandom); cfg_per = 8'($urandom); cfg_off = 8'($urandom); cfg_bur = 8'($urandom);
    endtask

    task automatic run_frame(input string tag, input bit en, input int per, input int off,
                             input int bur, input bit poke_start);
        int t, n_en, bad_pay, bad_tail, bad_inj, exp_inj, exp_err, exp_done;
        logic [1:0] e;
        logic [7:0] first8;
        begin_frame(en, per, off, bur);
        chk({tag, ":busy"}, 64'(busy), 64'(1));
        t = 0;
        while (done_cnt == 0 && t < 1000) begin
            @(negedge clk);
            t++;
            start = (poke_start && ft == 100);
        end
        start = 1'b0;
        chk({tag, ":done_timeout"}, 64'(t < 1000), 64'(1));
        repeat (6) @(negedge clk);
        n_en = 0; bad_pay = 0; bad_tail = 0; bad_inj = 0; exp_inj = 0; exp_err = 0;
        for (int i = 0; i < TMAX; i++) begin
            if (rec_en[i] === 1'b1) n_en++;
            if (i < FRAME_LEN && rec_bit[i] !== prbs[i]) bad_pay++;
            if (i >= FRAME_LEN && i < NPOS && rec_bit[i] !== 1'b0) bad_tail++;
            e = (i >= INJ_DLY && i - INJ_DLY < NPOS && pos_active(i - INJ_DLY, en, per, off, bur))
                ? 2'b10 : 2'b00;
            if (rec_inj[i] !== e) bad_inj++;
        end
        for (int p = 0; p < NPOS; p++) if (pos_active(p, en, per, off, bur)) exp_inj++;
        for (int i = 0; i < FRAME_LEN; i++) if (inv[i]) exp_err++;
        for (int k = 0; k < 8; k++) first8[7-k] = rec_bit[k];
        exp_done = (NPOS + 1 > FRAME_LEN + DEC_LAT) ? NPOS + 1 : FRAME_LEN + DEC_LAT;
        chk({tag, ":enc_en_cycles"}, 64'(n_en), 64'(NPOS));
        chk({tag, ":first8"}, 64'(first8), 64'(8'hFE));
        chk({tag, ":payload_bad"}, 64'(bad_pay), 64'(0));
        chk({tag, ":tail_bad"}, 64'(bad_tail), 64'(0));
        chk({tag, ":inj_pattern_bad"}, 64'(bad_inj), 64'(0));
        chk({tag, ":done_pulses"}, 64'(done_cnt), 64'(1));
        chk({tag, ":done_cycle"}, 64'(done_ft), 64'(exp_done));
        chk({tag, ":bit_err_ct"}, 64'(bit_err_ct), 64'(exp_err));
        chk({tag, ":inj_ct"}, 64'(inj_ct), 64'(exp_inj));
        chk({tag, ":idle_after"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int t;
        for (int i = 0; i < 7; i++) prbs[i] = SEED[6-i];
        for (int n = 7; n < NPOS; n++) prbs[n] = prbs[n-7] ^ prbs[n-6];
        clear_inv();

        #1;
        chk("reset_outputs", 64'({enc_en, enc_bit, err_inj, busy, done, bit_err_ct, inj_ct}), 64'(0));
        chk("reset_small", 64'({s_enc_en, s_err_inj, s_busy, s_done, s_bit_err, s_inj}), 64'(0));
        #21 rst = 1'b1;
        repeat (2) @(negedge clk);

        run_frame("clean", 1'b0, 16, 3, 2, 1'b1);
        chk("clean:errors_zero", 64'({bit_err_ct, inj_ct}), 64'(0));

        run_frame("periodic", 1'b1, 16, 3, 2, 1'b0);
        chk("periodic:pos3", 64'(rec_inj[4]), 64'(2'b10));
        chk("periodic:pos2", 64'(rec_inj[3]), 64'(2'b00));
        chk("periodic:pos19", 64'(rec_inj[20]), 64'(2'b10));
        chk("periodic:inj32", 64'(inj_ct), 64'(32));

        inv[0] = 1'b1; inv[100] = 1'b1; inv[255] = 1'b1; inv[256] = 1'b1;
        run_frame("mismatch", 1'b0, 0, 0, 0, 1'b0);
        chk("mismatch:three", 64'(bit_err_ct), 64'(3));
        clear_inv();

        run_frame("burst_clip", 1'b1, 16, 10, 20, 1'b0);
        chk("burst_clip:inj96", 64'(inj_ct), 64'(96));
        run_frame("period0", 1'b1, 0, 0, 5, 1'b0);
        run_frame("offset_ge_period", 1'b1, 8, 8, 4, 1'b0);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < TMAX; i++) inv[i] = ($urandom_range(0, 31) == 0);
            run_frame($sformatf("rand%0d", k), (k == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 40)), int'($urandom_range(0, 45)),
                      int'($urandom_range(0, 10)), 1'b0);
        end
        clear_inv();

        // Abort in payload cycle 50
        begin_frame(1'b1, 4, 0, 2);
        t = 0;
        while (ft != 50 && t < 200) begin @(negedge clk); t++; end
        chk("abort:reach50", 64'(ft), 64'(50));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort:outputs", 64'({enc_en, err_inj, busy, done}), 64'(0));
        repeat (20) @(negedge clk);
        chk("abort:no_done", 64'(done_cnt), 64'(0));
        run_frame("after_abort", 1'b0, 0, 0, 0, 1'b0);

        // Async reset in the tail
        begin_frame(1'b1, 4, 0, 2);
        t = 0;
        while (ft != FRAME_LEN && t < 400) begin @(negedge clk); t++; end
        chk("rst_tail:reach", 64'(ft), 64'(FRAME_LEN));
        chk("rst_tail:inj_nonzero", 64'(inj_ct != 16'd0), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("rst_tail:outputs", 64'({enc_en, enc_bit, err_inj, busy, done, bit_err_ct, inj_ct}), 64'(0));
        #4 rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_tail:no_done", 64'(done_cnt), 64'(0));
        chk("rst_tail:idle", 64'(busy), 64'(0));

        // Small build: every payload bit decoded wrong, counters saturate at 15
        @(negedge clk);
        s_cfg_en = 1'b1; s_per = 8'd4; s_off = 8'd1; s_bur = 8'd2;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        t = 0;
        while (s_done_cnt == 0 && t < 200) begin @(negedge clk); t++; end
        chk("small:done_timeout", 64'(t < 200), 64'(1));
        repeat (4) @(negedge clk);
        chk("small:bit_err_sat", 64'(s_bit_err), 64'(15));
        chk("small:inj_ct", 64'(s_inj), 64'(10));
        chk("small:inj_cycles", 64'(s_inj_cyc), 64'(10));
        chk("small:inj_outside_en", 64'(s_inj_off), 64'(0));
        chk("small:done_pulses", 64'(s_done_cnt), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
